ibex_multdiv_iter: RTL

//  Parametrised iterative multiply/divide unit. Computes MULL/MULH[SU|U]/DIV[U]/REM[U] on WIDTH-bit operands.

---
 rtl/ibex_pkg.sv | 11 +
 rtl/ibex_multdiv_iter_if.sv | 36 +++
 rtl/ibex_cond_negate.sv | 12 +
 rtl/ibex_multdiv_iter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex encodings used by the iterative multiply/divide unit.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Request/response handshake bundle between the ID/EX stage (master) and the multdiv unit (slave).
interface ibex_multdiv_iter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    import ibex_pkg::*;

    logic             req_valid_i;
    logic             req_ready_o;
    md_op_e           req_op_i;
    logic [1:0]       req_signed_i;
    logic [WIDTH-1:0] req_a_i;
    logic [WIDTH-1:0] req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             data_ind_timing_i;
    logic             kill_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] resp_result_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             resp_div_zero_o;
    logic             busy_o;

    modport master (
        output req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i, req_tag_i,
               data_ind_timing_i, kill_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_tag_o, resp_div_zero_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_signed_i, req_a_i, req_b_i, req_tag_i,
               data_ind_timing_i, kill_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_tag_o, resp_div_zero_o, busy_o
    );

endinterface

// File: rtl/ibex_cond_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module ibex_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + {{(WIDTH-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply (MUL_BITS per cycle, early exit) and restoring divide on operand magnitudes,
// with sign fix-up in a dedicated FIX cycle, kill and response backpressure.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    ibex_multdiv_iter_if.slave md
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int POS_W = $clog2(2 * WIDTH);
    localparam int PP_W  = WIDTH + MUL_BITS;

    state_e             state_q, state_d;
    md_op_e             op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               dit_q, dit_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               in_sign_a, in_sign_b, in_div_zero;
    logic [PP_W-1:0]    pp;
    logic [2*WIDTH-1:0] pp_sh;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   diff_lo;
    logic               borrow;
    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic               fix_neg;

    assign in_sign_a   = md.req_signed_i[0] & md.req_a_i[WIDTH-1];
    assign in_sign_b   = md.req_signed_i[1] & md.req_b_i[WIDTH-1];
    assign in_div_zero = md.req_op_i[1] & (md.req_b_i == '0);

    ibex_cond_negate #(.WIDTH(WIDTH)) u_abs_a (.neg_i(in_sign_a), .in_i(md.req_a_i), .out_o(abs_a));
    ibex_cond_negate #(.WIDTH(WIDTH)) u_abs_b (.neg_i(in_sign_b), .in_i(md.req_b_i), .out_o(abs_b));
    ibex_cond_negate #(.WIDTH(2*WIDTH)) u_fix (.neg_i(fix_neg), .in_i(fix_in), .out_o(fix_out));

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (b_q[i]) pp = pp + (PP_W'(a_q) << i);
        end
        pp_sh = (2*WIDTH)'(pp) << pos_q;
    end

    // Remainder lives in acc[2W-1:W], quotient shifts in at acc[0]; dividend bits come from a_q's MSB.
    // A set rem_shift[WIDTH] means the shifted remainder already exceeds any divisor.
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign diff_lo   = rem_shift[WIDTH-1:0] - b_q;
    assign borrow    = ~rem_shift[WIDTH] & (rem_shift[WIDTH-1:0] < b_q);

    always_comb begin
        fix_in  = acc_q;
        fix_neg = sign_a_q ^ sign_b_q;
        case (op_q)
            MD_OP_DIV: begin
                fix_in  = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
                fix_neg = (sign_a_q ^ sign_b_q) & ~div_zero_q;
            end
            MD_OP_REM: begin
                fix_in  = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
                fix_neg = sign_a_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        dit_d      = dit_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        count_d    = count_q;
        pos_d      = pos_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_IDLE: begin
                if (md.req_valid_i & ~md.kill_i) begin
                    op_d       = md.req_op_i;
                    tag_d      = md.req_tag_i;
                    dit_d      = md.data_ind_timing_i;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    a_d        = abs_a;
                    b_d        = abs_b;
                    acc_d      = '0;
                    pos_d      = '0;
                    count_d    = md.req_op_i[1] ? CNT_W'(WIDTH) : CNT_W'(WIDTH / MUL_BITS);
                    div_zero_d = in_div_zero;
                    if (in_div_zero & ~md.data_ind_timing_i) begin
                        result_d = (md.req_op_i == MD_OP_DIV) ? '1 : md.req_a_i;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                count_d = count_q - 1'b1;
                if (!op_q[1]) begin
                    acc_d = acc_q + pp_sh;
                    b_d   = b_q >> MUL_BITS;
                    pos_d = pos_q + POS_W'(MUL_BITS);
                    if ((count_d == '0) || ((b_d == '0) && !dit_q)) state_d = S_FIX;
                end else begin
                    acc_d = {(borrow ? rem_shift[WIDTH-1:0] : diff_lo), acc_q[WIDTH-2:0], ~borrow};
                    a_d   = {a_q[WIDTH-2:0], 1'b0};
                    if (count_d == '0) state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = (op_q == MD_OP_MULH) ? fix_out[2*WIDTH-1:WIDTH] : fix_out[WIDTH-1:0];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (md.resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (md.kill_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            op_q       <= MD_OP_MULL;
            tag_q      <= '0;
            dit_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            pos_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            dit_q      <= dit_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            pos_q      <= pos_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign md.req_ready_o     = (state_q == S_IDLE) & ~md.kill_i;
    assign md.resp_valid_o    = (state_q == S_DONE) & ~md.kill_i;
    assign md.resp_result_o   = result_q;
    assign md.resp_tag_o      = tag_q;
    assign md.resp_div_zero_o = div_zero_q;
    assign md.busy_o          = (state_q != S_IDLE);

endmodule
